// File: rtl/qupls4_rd_decode_stage_if.sv
// Qupls4 Rd-decode stage: shared micro-op/operating-mode types and the stage's handshake bundle.
// slave modport is the stage itself; master modport is whatever drives and consumes it.
package qupls4_rd_pkg;
  typedef enum logic [1:0] {
    OM_USER    = 2'd0,
    OM_SUPER   = 2'd1,
    OM_HYPER   = 2'd2,
    OM_MACHINE = 2'd3
  } operating_mode_t;

  localparam logic [6:0] OP_ADDI    = 7'd4;
  localparam logic [6:0] OP_SUBFI   = 7'd5;
  localparam logic [6:0] OP_CMPI    = 7'd6;
  localparam logic [6:0] OP_CMPUI   = 7'd7;
  localparam logic [6:0] OP_ANDI    = 7'd8;
  localparam logic [6:0] OP_ORI     = 7'd9;
  localparam logic [6:0] OP_XORI    = 7'd10;
  localparam logic [6:0] OP_MULI    = 7'd12;
  localparam logic [6:0] OP_MULUI   = 7'd13;
  localparam logic [6:0] OP_DIVI    = 7'd14;
  localparam logic [6:0] OP_DIVUI   = 7'd15;
  localparam logic [6:0] OP_SHIFT   = 7'd16;
  localparam logic [6:0] OP_CSR     = 7'd17;
  localparam logic [6:0] OP_B0      = 7'd32;
  localparam logic [6:0] OP_B1      = 7'd33;
  localparam logic [6:0] OP_BCC0    = 7'd34;
  localparam logic [6:0] OP_BCC1    = 7'd35;
  localparam logic [6:0] OP_LDB     = 7'd64;
  localparam logic [6:0] OP_LDBZ    = 7'd65;
  localparam logic [6:0] OP_LDW     = 7'd66;
  localparam logic [6:0] OP_LDWZ    = 7'd67;
  localparam logic [6:0] OP_LDT     = 7'd68;
  localparam logic [6:0] OP_LDTZ    = 7'd69;
  localparam logic [6:0] OP_LOAD    = 7'd70;
  localparam logic [6:0] OP_LOADA   = 7'd71;
  localparam logic [6:0] OP_LDV     = 7'd72;
  localparam logic [6:0] OP_AMO     = 7'd73;
  localparam logic [6:0] OP_CMPSWAP = 7'd74;
  localparam logic [6:0] OP_FLTH    = 7'd80;
  localparam logic [6:0] OP_FLTS    = 7'd81;
  localparam logic [6:0] OP_FLTD    = 7'd82;
  localparam logic [6:0] OP_FLTQ    = 7'd83;

  // All formats keep the opcode in [31:25]; the destination field moves per format.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [10:0] imm;
    logic [6:0]  rs1;
    logic [6:0]  rd;
  } alui_fmt_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [3:0] fn;
    logic [6:0] rd;
    logic [6:0] rs1;
    logic [6:0] rs2;
  } fpu_fmt_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [10:0] regno;
    logic [6:0]  rd;
    logic [6:0]  rs1;
  } csr_fmt_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [15:0] disp;
    logic [2:0]  rd;
    logic [5:0]  cnd;
  } bsr_fmt_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [10:0] disp;
    logic [6:0]  rs1;
    logic [6:0]  rsd;
  } ls_fmt_t;

  typedef union packed {
    alui_fmt_t   alui;
    fpu_fmt_t    fpu;
    csr_fmt_t    csr;
    bsr_fmt_t    bsr;
    ls_fmt_t     ls;
    logic [31:0] raw;
  } micro_op_t;
endpackage

interface qupls4_rd_decode_stage_if
  import qupls4_rd_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int AREG_W = 7
);
  logic                          flush;
  logic                          in_valid;
  logic                          in_ready;
  operating_mode_t               om;
  micro_op_t [LANES-1:0]         instr;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES-1:0][AREG_W-1:0]  Rd;
  logic [LANES-1:0]              Rdz;
  logic [LANES-1:0]              Rd_dead;
  logic [LANES-1:0]              exc;

  modport slave (
    input  flush, in_valid, om, instr, out_ready,
    output in_ready, out_valid, Rd, Rdz, Rd_dead, exc
  );

  modport master (
    output flush, in_valid, om, instr, out_ready,
    input  in_ready, out_valid, Rd, Rdz, Rd_dead, exc
  );
endinterface

// File: rtl/qupls4_rd_decode_stage.sv
// Registered multi-lane Rd decode with output register plus one-entry skid buffer.
// Optional same-group WAW marking (Rd_dead) is enabled by defining QUPLS4_RD_WAW_EN.
module qupls4_rd_decode_stage
  import qupls4_rd_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int AREG_W      = 7,
  parameter int USER_RD_MAX = 63
)(
  input  logic                   clk,
  input  logic                   rst_n,
  qupls4_rd_decode_stage_if.slave bus
);
  localparam int W = AREG_W + 3;
  localparam logic [AREG_W-1:0] USER_MAX = AREG_W'(USER_RD_MAX);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state_reg, state_next;
  logic   accept, retire, in_ready, out_valid;
  logic   load_out_dec, load_out_skid, load_skid;

  logic [LANES-1:0][AREG_W-1:0] dec_rd;
  logic [LANES-1:0]             dec_dead;
  logic [LANES-1:0][W-1:0]      dec_word, out_reg, skid_reg;

  // Per-lane word layout: {dead, exc, rdz, rd}
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [AREG_W-1:0] rd;
    logic [6:0]        opc;
    assign opc = bus.instr[gi].raw[31:25];

    always_comb begin
      rd = '0;
      case (opc)
        OP_FLTH, OP_FLTS, OP_FLTD, OP_FLTQ:
          rd = AREG_W'(bus.instr[gi].fpu.rd);
        OP_CSR:
          rd = AREG_W'(bus.instr[gi].csr.rd);
        OP_ADDI, OP_SUBFI, OP_CMPI, OP_CMPUI, OP_ANDI, OP_ORI, OP_XORI,
        OP_MULI, OP_MULUI, OP_DIVI, OP_DIVUI, OP_SHIFT:
          rd = AREG_W'(bus.instr[gi].alui.rd);
        OP_B0, OP_B1, OP_BCC0, OP_BCC1:
          rd = (bus.instr[gi].bsr.rd == 3'd7) ? '0 : AREG_W'(bus.instr[gi].bsr.rd);
        OP_LDB, OP_LDBZ, OP_LDW, OP_LDWZ, OP_LDT, OP_LDTZ, OP_LOAD, OP_LOADA,
        OP_LDV, OP_AMO, OP_CMPSWAP:
          rd = AREG_W'(bus.instr[gi].ls.rsd);
        default: rd = '0;
      endcase
    end

    assign dec_rd[gi]   = rd;
    assign dec_word[gi] = {dec_dead[gi],
                           (bus.om == OM_USER) && (rd > USER_MAX),
                           rd == '0,
                           rd};

`ifdef QUPLS4_RD_WAW_EN
    always_comb begin
      dec_dead[gi] = 1'b0;
      for (int j = gi + 1; j < LANES; j++)
        if (rd != '0 && dec_rd[j] == rd)
          dec_dead[gi] = 1'b1;
    end
`else
    assign dec_dead[gi] = 1'b0;
`endif

    assign bus.Rd[gi]      = out_reg[gi][AREG_W-1:0];
    assign bus.Rdz[gi]     = out_reg[gi][AREG_W];
    assign bus.exc[gi]     = out_reg[gi][AREG_W+1];
    assign bus.Rd_dead[gi] = out_reg[gi][AREG_W+2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= EMPTY;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.flush)
      state_next = EMPTY;
    else begin
      case (state_reg)
        EMPTY:   if (accept) state_next = ONE;
        ONE: begin
          if (accept && !retire)      state_next = TWO;
          else if (retire && !accept) state_next = EMPTY;
        end
        TWO:     if (retire) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // in_ready depends only on the state register, so out_ready never reaches it combinationally.
  always_comb begin
    in_ready      = (state_reg != TWO);
    out_valid     = (state_reg != EMPTY);
    accept        = bus.in_valid && in_ready;
    retire        = out_valid && bus.out_ready;
    load_out_dec  = accept && ((state_reg == EMPTY) || (state_reg == ONE && retire));
    load_skid     = accept && (state_reg == ONE) && !retire;
    load_out_skid = (state_reg == TWO) && retire;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg  <= '0;
      skid_reg <= '0;
    end else if (!bus.flush) begin
      if (load_out_dec)
        out_reg <= dec_word;
      else if (load_out_skid)
        out_reg <= skid_reg;
      if (load_skid)
        skid_reg <= dec_word;
    end
  end
endmodule

// File: tb/tb_qupls4_rd_decode_stage.sv
// Bench for qupls4_rd_decode_stage: queue-based group model checked every cycle plus directed literal checks.
module tb_qupls4_rd_decode_stage;
  import qupls4_rd_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qupls4_rd_decode_stage_if #(.LANES(4), .AREG_W(7)) bus();

  qupls4_rd_decode_stage #(.LANES(4), .AREG_W(7), .USER_RD_MAX(63)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

`ifdef QUPLS4_RD_WAW_EN
  localparam logic [3:0] DEAD_EXP = 4'b0001;
`else
  localparam logic [3:0] DEAD_EXP = 4'b0000;
`endif

  typedef struct {
    logic [3:0][6:0] rd;
    logic [3:0]      rdz;
    logic [3:0]      dead;
    logic [3:0]      exc;
  } grp_t;

  int tests = 0;
  int fails = 0;
  grp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic grp_t model(input micro_op_t [3:0] g, input operating_mode_t m);
    grp_t r;
    for (int i = 0; i < 4; i++) begin
      logic [6:0] op;
      op = g[i].raw[31:25];
      if (op inside {OP_FLTH, OP_FLTS, OP_FLTD, OP_FLTQ})
        r.rd[i] = g[i].fpu.rd;
      else if (op == OP_CSR)
        r.rd[i] = g[i].csr.rd;
      else if (op inside {OP_ADDI, OP_SUBFI, OP_CMPI, OP_CMPUI, OP_ANDI, OP_ORI, OP_XORI,
                          OP_MULI, OP_MULUI, OP_DIVI, OP_DIVUI, OP_SHIFT})
        r.rd[i] = g[i].alui.rd;
      else if (op inside {OP_B0, OP_B1, OP_BCC0, OP_BCC1})
        r.rd[i] = (g[i].bsr.rd == 3'd0 || g[i].bsr.rd == 3'd7) ? 7'd0 : {4'd0, g[i].bsr.rd};
      else if (op inside {OP_LDB, OP_LDBZ, OP_LDW, OP_LDWZ, OP_LDT, OP_LDTZ, OP_LOAD,
                          OP_LOADA, OP_LDV, OP_AMO, OP_CMPSWAP})
        r.rd[i] = g[i].ls.rsd;
      else
        r.rd[i] = 7'd0;
      r.rdz[i] = (r.rd[i] == 7'd0);
      r.exc[i] = (m == OM_USER) && (int'(r.rd[i]) > 63);
    end
    for (int i = 0; i < 4; i++) begin
      r.dead[i] = 1'b0;
`ifdef QUPLS4_RD_WAW_EN
      for (int j = i + 1; j < 4; j++)
        if (r.rd[i] != 7'd0 && r.rd[j] == r.rd[i]) r.dead[i] = 1'b1;
`endif
    end
    return r;
  endfunction

  // Model: a FIFO of at most two groups; accept when fewer than two are held.
  always @(posedge clk or negedge rst_n) begin : monitor
    bit acc, ret;
    if (!rst_n)
      q.delete();
    else begin
      acc = bus.in_valid && (q.size() < 2);
      ret = (q.size() > 0) && bus.out_ready;
      if (bus.flush)
        q.delete();
      else begin
        if (ret) void'(q.pop_front());
        if (acc) q.push_back(model(bus.instr, bus.om));
      end
    end
  end

  always @(negedge clk) begin : compare
    if (rst_n) begin
      check("cmp_out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      check("cmp_in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      if (q.size() != 0) begin
        check("cmp_Rd", 64'(bus.Rd), 64'(q[0].rd));
        check("cmp_Rdz", 64'(bus.Rdz), 64'(q[0].rdz));
        check("cmp_Rd_dead", 64'(bus.Rd_dead), 64'(q[0].dead));
        check("cmp_exc", 64'(bus.exc), 64'(q[0].exc));
      end
    end
  end

  function automatic micro_op_t op_alui(input logic [6:0] op, input logic [6:0] rd);
    micro_op_t u;
    u.raw = '0; u.alui.opcode = op; u.alui.imm = 11'h2AB; u.alui.rs1 = 7'h33; u.alui.rd = rd;
    return u;
  endfunction
  function automatic micro_op_t op_fpu(input logic [6:0] op, input logic [6:0] rd);
    micro_op_t u;
    u.raw = '0; u.fpu.opcode = op; u.fpu.fn = 4'h9; u.fpu.rd = rd; u.fpu.rs1 = 7'h0E; u.fpu.rs2 = 7'h19;
    return u;
  endfunction
  function automatic micro_op_t op_csr(input logic [6:0] rd);
    micro_op_t u;
    u.raw = '0; u.csr.opcode = OP_CSR; u.csr.regno = 11'h345; u.csr.rd = rd; u.csr.rs1 = 7'h11;
    return u;
  endfunction
  function automatic micro_op_t op_ls(input logic [6:0] op, input logic [6:0] rsd);
    micro_op_t u;
    u.raw = '0; u.ls.opcode = op; u.ls.disp = 11'h155; u.ls.rs1 = 7'h22; u.ls.rsd = rsd;
    return u;
  endfunction
  function automatic micro_op_t op_br(input logic [6:0] op, input logic [2:0] rd3);
    micro_op_t u;
    u.raw = '0; u.bsr.opcode = op; u.bsr.disp = 16'h1234; u.bsr.rd = rd3; u.bsr.cnd = 6'h2A;
    return u;
  endfunction
  function automatic micro_op_t op_unk();
    micro_op_t u;
    u.raw = 32'h0ACE_5A5A; u.raw[31:25] = 7'h7E;
    return u;
  endfunction

  task automatic send(input micro_op_t [3:0] g, input operating_mode_t m);
    int n;
    bus.instr = g; bus.om = m; bus.in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("accept_wait", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  micro_op_t [3:0] g;

  initial begin
    rst_n = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.om = OM_MACHINE; bus.instr = '0;
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_Rd", 64'(bus.Rd), 64'd0);
    check("rst_Rdz", 64'(bus.Rdz), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single group: ADDI 5, LDB 9, unknown, CSR 12
    g[0] = op_alui(OP_ADDI, 7'd5); g[1] = op_ls(OP_LDB, 7'd9);
    g[2] = op_unk();               g[3] = op_csr(7'd12);
    send(g, OM_MACHINE);
    check("g1_out_valid", 64'(bus.out_valid), 64'd1);
    check("g1_Rd", 64'(bus.Rd), 64'({7'd12, 7'd0, 7'd9, 7'd5}));
    check("g1_Rdz", 64'(bus.Rdz), 64'(4'b0100));

    // More opcode classes
    g[0] = op_fpu(OP_FLTD, 7'd40); g[1] = op_alui(OP_MULUI, 7'd17);
    g[2] = op_ls(OP_AMO, 7'd2);    g[3] = op_br(OP_B1, 3'd5);
    send(g, OM_SUPER);
    check("g2_Rd", 64'(bus.Rd), 64'({7'd5, 7'd2, 7'd17, 7'd40}));

    // Branch link: [8:6]=7 forces 0, then 3 passes through
    g[0] = op_br(OP_B0, 3'd7); g[1] = op_unk(); g[2] = op_unk(); g[3] = op_unk();
    send(g, OM_MACHINE);
    check("br7_Rd0", 64'(bus.Rd[0]), 64'd0);
    check("br7_Rdz0", 64'(bus.Rdz[0]), 64'd1);
    g[0] = op_br(OP_BCC1, 3'd3);
    send(g, OM_MACHINE);
    check("br3_Rd0", 64'(bus.Rd[0]), 64'd3);
    check("br3_Rdz0", 64'(bus.Rdz[0]), 64'd0);

    // Privilege: Rd 70 in user mode traps, Rd 63 does not, machine mode never does
    g[0] = op_alui(OP_ADDI, 7'd70); g[1] = op_alui(OP_ADDI, 7'd63);
    send(g, OM_USER);
    check("usr_exc", 64'(bus.exc), 64'(4'b0001));
    check("usr_Rd0", 64'(bus.Rd[0]), 64'd70);
    send(g, OM_MACHINE);
    check("mach_exc", 64'(bus.exc), 64'd0);

    // WAW within a group
    g[0] = op_alui(OP_ADDI, 7'd4); g[1] = op_ls(OP_LDW, 7'd7);
    g[2] = op_alui(OP_ORI, 7'd4);  g[3] = op_unk();
    send(g, OM_MACHINE);
    check("waw_dead", 64'(bus.Rd_dead), 64'(DEAD_EXP));
    g[0] = op_unk(); g[1] = op_unk(); g[2] = op_unk();
    send(g, OM_MACHINE);
    check("waw_zero_dead", 64'(bus.Rd_dead), 64'd0);
    @(posedge clk); #1;

    // Backpressure: A, B held, C waits; then A, B, C on consecutive cycles
    bus.out_ready = 1'b0;
    g = '{op_unk(), op_unk(), op_unk(), op_alui(OP_XORI, 7'd21)};
    send(g, OM_MACHINE);
    g[0] = op_alui(OP_XORI, 7'd22);
    send(g, OM_MACHINE);
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("bp_hold_A", 64'(bus.Rd[0]), 64'd21);
    fork
      begin
        micro_op_t [3:0] gc;
        gc = g; gc[0] = op_alui(OP_XORI, 7'd23);
        send(gc, OM_MACHINE);
      end
      begin
        @(posedge clk); #1;
        check("bp_stable_A", 64'(bus.Rd[0]), 64'd21);
        bus.out_ready = 1'b1;
        @(negedge clk); check("bp_seq_A", 64'(bus.Rd[0]), 64'd21);
        @(negedge clk); check("bp_seq_B", 64'(bus.Rd[0]), 64'd22);
        @(negedge clk); check("bp_seq_C", 64'(bus.Rd[0]), 64'd23);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Flush in TWO with a group presented: everything is lost
    bus.out_ready = 1'b0;
    g[0] = op_alui(OP_ANDI, 7'd31); send(g, OM_MACHINE);
    g[0] = op_alui(OP_ANDI, 7'd32); send(g, OM_MACHINE);
    g[0] = op_alui(OP_ANDI, 7'd33);
    bus.instr = g; bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush_lost", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Asynchronous reset mid-cycle while in ONE
    bus.out_ready = 1'b0;
    g[0] = op_alui(OP_ADDI, 7'd70); g[1] = op_alui(OP_ADDI, 7'd70);
    send(g, OM_USER);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_Rd", 64'(bus.Rd), 64'd0);
    check("arst_Rdz", 64'(bus.Rdz), 64'd0);
    check("arst_exc", 64'(bus.exc), 64'd0);
    check("arst_dead", 64'(bus.Rd_dead), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
